// File: rtl/dcache_ecc_scrubber.sv
// rtl/dcache_ecc_scrubber.sv - background ECC scrubber for the data cache arrays
module dcache_ecc_scrubber #(
    parameter int NUM_SETS       = 256,
    parameter int SET_ASSOC      = 8,
    parameter int DATA_WIDTH     = 128,
    parameter int INTERVAL_WIDTH = 16,
    parameter int IDX_WIDTH      = $clog2(NUM_SETS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic [INTERVAL_WIDTH-1:0]       interval_i,
    input  logic                            clr_cnt_i,
    output logic [SET_ASSOC-1:0]            req_o,
    input  logic                            gnt_i,
    output logic [IDX_WIDTH-1:0]            addr_o,
    output logic                            we_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    input  logic [SET_ASSOC*DATA_WIDTH-1:0] rdata_i,
    input  logic [2*SET_ASSOC-1:0]          err_i,
    input  logic                            ext_wr_i,
    input  logic [IDX_WIDTH-1:0]            ext_idx_i,
    output logic                            busy_o,
    output logic [15:0]                     corr_cnt_o,
    output logic [15:0]                     uncorr_cnt_o,
    output logic                            uncorr_irq_o,
    output logic [IDX_WIDTH-1:0]            uncorr_idx_o,
    output logic [$clog2(SET_ASSOC)-1:0]    uncorr_way_o
);
    localparam int WAY_W = $clog2(SET_ASSOC);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_WRITE, S_NEXT} state_t;

    function automatic logic [SET_ASSOC-1:0] lowest_oh(input logic [SET_ASSOC-1:0] m);
        return m & (~m + 1'b1);
    endfunction

    function automatic logic [WAY_W-1:0] lowest_idx(input logic [SET_ASSOC-1:0] m);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = SET_ASSOC - 1; i >= 0; i--)
            if (m[i]) r = WAY_W'(i);
        return r;
    endfunction

    function automatic logic [16:0] popcnt(input logic [SET_ASSOC-1:0] m);
        logic [16:0] c;
        c = '0;
        for (int i = 0; i < SET_ASSOC; i++) c = c + 17'(m[i]);
        return c;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [16:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + inc;
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t                    r_state;
    logic [INTERVAL_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0]      r_idx;
    logic [SET_ASSOC-1:0]      r_pend;
    logic [SET_ASSOC-1:0]      r_req;
    logic [IDX_WIDTH-1:0]      r_addr;
    logic                      r_we;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [15:0]               r_corr_cnt;
    logic [15:0]               r_unc_cnt;
    logic                      r_irq;
    logic [IDX_WIDTH-1:0]      r_unc_idx;
    logic [WAY_W-1:0]          r_unc_way;
    logic [DATA_WIDTH-1:0]     r_data [SET_ASSOC];

    logic [SET_ASSOC-1:0]      w_corr, w_unc, w_chk_oh, w_left, w_wr_oh;
    logic [DATA_WIDTH-1:0]     w_chk_data, w_wr_data;
    logic                      w_ext_hit;

    // w_left is what remains pending once the write currently on the port is granted
    always_comb begin
        w_corr     = '0;
        w_unc      = '0;
        w_chk_data = '0;
        w_wr_data  = '0;
        for (int w = 0; w < SET_ASSOC; w++) begin
            w_corr[w] = (err_i[2*w +: 2] == 2'b01);
            w_unc[w]  = err_i[2*w+1];
        end
        w_chk_oh = lowest_oh(w_corr);
        w_left   = r_pend & ~r_req;
        w_wr_oh  = lowest_oh(w_left);
        for (int w = 0; w < SET_ASSOC; w++) begin
            if (w_chk_oh[w]) w_chk_data = rdata_i[w*DATA_WIDTH +: DATA_WIDTH];
            if (w_wr_oh[w])  w_wr_data  = r_data[w];
        end
    end

    assign w_ext_hit = ext_wr_i && (ext_idx_i == r_idx);

    always_ff @(posedge clk_i) begin
        if (r_state == S_CHECK)
            for (int w = 0; w < SET_ASSOC; w++) r_data[w] <= rdata_i[w*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_pend     <= '0;
            r_req      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
            r_irq      <= 1'b0;
            r_unc_idx  <= '0;
            r_unc_way  <= '0;
        end else begin
            r_irq <= 1'b0;
            if (clr_cnt_i) begin
                r_corr_cnt <= '0;
                r_unc_cnt  <= '0;
            end else if (r_state == S_CHECK) begin
                r_corr_cnt <= sat_add(r_corr_cnt, popcnt(w_corr));
                r_unc_cnt  <= sat_add(r_unc_cnt, popcnt(w_unc));
            end
            case (r_state)
                S_IDLE: if (en_i) begin
                    r_state <= S_WAIT;
                    r_cnt   <= interval_i;
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (en_i) begin
                        r_state <= S_READ;
                        r_req   <= '1;
                        r_we    <= 1'b0;
                        r_addr  <= r_idx;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: if (gnt_i) begin
                    r_state <= S_CHECK;
                    r_req   <= '0;
                end
                S_CHECK: begin
                    if (|w_unc) begin
                        r_irq     <= 1'b1;
                        r_unc_idx <= r_idx;
                        r_unc_way <= lowest_idx(w_unc);
                    end
                    if (!w_ext_hit && (|w_corr)) begin
                        r_state <= S_WRITE;
                        r_pend  <= w_corr;
                        r_req   <= w_chk_oh;
                        r_we    <= 1'b1;
                        r_wdata <= w_chk_data;
                    end else begin
                        r_state <= S_NEXT;
                        r_pend  <= '0;
                    end
                end
                S_WRITE: begin
                    if (gnt_i && !w_ext_hit && (|w_left)) begin
                        r_pend  <= w_left;
                        r_req   <= w_wr_oh;
                        r_wdata <= w_wr_data;
                    end else if (gnt_i || w_ext_hit) begin
                        r_state <= S_NEXT;
                        r_pend  <= '0;
                        r_req   <= '0;
                        r_we    <= 1'b0;
                    end
                end
                S_NEXT: begin
                    r_idx <= r_idx + 1'b1;
                    if (en_i) begin
                        r_state <= S_WAIT;
                        r_cnt   <= interval_i;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_o        = r_req;
    assign addr_o       = r_addr;
    assign we_o         = r_we;
    assign wdata_o      = r_wdata;
    assign busy_o       = (r_state != S_IDLE);
    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_unc_cnt;
    assign uncorr_irq_o = r_irq;
    assign uncorr_idx_o = r_unc_idx;
    assign uncorr_way_o = r_unc_way;
endmodule

// File: tb/tb_dcache_ecc_scrubber.sv
// tb/tb_dcache_ecc_scrubber.sv - directed self-checking bench for dcache_ecc_scrubber
module tb_dcache_ecc_scrubber;
    localparam int NS   = 4;
    localparam int SA   = 8;
    localparam int DW   = 32;
    localparam int IW   = 8;
    localparam int IDXW = 2;
    localparam int WW   = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             en_i;
    logic [IW-1:0]    interval_i;
    logic             clr_cnt_i;
    logic [SA-1:0]    req_o;
    logic             gnt_i;
    logic [IDXW-1:0]  addr_o;
    logic             we_o;
    logic [DW-1:0]    wdata_o;
    logic [SA*DW-1:0] rdata_i;
    logic [2*SA-1:0]  err_i;
    logic             ext_wr_i;
    logic [IDXW-1:0]  ext_idx_i;
    logic             busy_o;
    logic [15:0]      corr_cnt_o;
    logic [15:0]      uncorr_cnt_o;
    logic             uncorr_irq_o;
    logic [IDXW-1:0]  uncorr_idx_o;
    logic [WW-1:0]    uncorr_way_o;

    dcache_ecc_scrubber #(
        .NUM_SETS(NS), .SET_ASSOC(SA), .DATA_WIDTH(DW), .INTERVAL_WIDTH(IW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .interval_i(interval_i),
        .clr_cnt_i(clr_cnt_i), .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o),
        .we_o(we_o), .wdata_o(wdata_o), .rdata_i(rdata_i), .err_i(err_i),
        .ext_wr_i(ext_wr_i), .ext_idx_i(ext_idx_i), .busy_o(busy_o),
        .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
        .uncorr_irq_o(uncorr_irq_o), .uncorr_idx_o(uncorr_idx_o),
        .uncorr_way_o(uncorr_way_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;
    int irq_n = 0;
    int rd_addr[$];
    int rd_cyc[$];
    int wr_addr[$];
    logic [SA-1:0] wr_req[$];
    logic [DW-1:0] wr_data[$];
    logic [2*SA-1:0] em [NS];

    function automatic logic [DW-1:0] wd(input int s, input int w);
        return {s[7:0], w[7:0], 16'hA5C3};
    endfunction

    function automatic logic [SA*DW-1:0] line_of(input int s);
        logic [SA*DW-1:0] l;
        for (int w = 0; w < SA; w++) l[w*DW +: DW] = wd(s, w);
        return l;
    endfunction

    // memory model and port monitor
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_ni) begin
            rdata_i <= '0;
            err_i   <= '0;
        end else begin
            if (gnt_i && !we_o && req_o == '1) begin
                rd_addr.push_back(int'(addr_o));
                rd_cyc.push_back(cyc);
                rdata_i <= line_of(int'(addr_o));
                err_i   <= em[addr_o];
            end
            if (gnt_i && we_o) begin
                wr_addr.push_back(int'(addr_o));
                wr_req.push_back(req_o);
                wr_data.push_back(wdata_o);
            end
            if (uncorr_irq_o) irq_n <= irq_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        en_i = 1'b0; gnt_i = 1'b0; ext_wr_i = 1'b0; ext_idx_i = '0;
        clr_cnt_i = 1'b0; interval_i = '0;
        for (int s = 0; s < NS; s++) em[s] = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, wb, bi, rb, hold_ok;
        rst_ni = 1'b0;
        en_i = 1'b0; gnt_i = 1'b0; ext_wr_i = 1'b0; ext_idx_i = '0;
        clr_cnt_i = 1'b0; interval_i = '0;
        for (int s = 0; s < NS; s++) em[s] = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_req", req_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
        chk("rst_irq", {uncorr_irq_o, uncorr_idx_o, uncorr_way_o}, 0);

        // clean sweep: interval 2 gives a 6-cycle set period
        rst_ni = 1'b1;
        @(negedge clk_i);
        b = rd_addr.size(); wb = wr_addr.size();
        interval_i = 8'd2; gnt_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 200 && rd_addr.size() < b + 5; i++) @(negedge clk_i);
        chk("sweep_read_count", rd_addr.size() >= b + 5, 1);
        for (int k = 0; k < 5; k++) chk($sformatf("sweep_addr%0d", k), rd_addr[b+k], k % 4);
        for (int k = 1; k < 5; k++) chk($sformatf("sweep_gap%0d", k), rd_cyc[b+k] - rd_cyc[b+k-1], 6);
        chk("sweep_no_write", wr_addr.size() - wb, 0);
        chk("sweep_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
        en_i = 1'b0;
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
        chk("sweep_idle", busy_o, 0);

        // asynchronous reset drops a pending read request at once
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 20 && req_o != '1; i++) @(negedge clk_i);
        chk("arst_req_seen", req_o, 8'hFF);
        #2 rst_ni = 1'b0;
        #1 chk("arst_req_drop", req_o, 0);
        chk("arst_busy", busy_o, 0);

        // correctable ways 2 and 5 at set 1
        do_reset();
        em[1] = (16'h1 << 4) | (16'h1 << 10);
        wb = wr_addr.size();
        gnt_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 200 && wr_addr.size() < wb + 2; i++) @(negedge clk_i);
        en_i = 1'b0;
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
        chk("corr_write_count", wr_addr.size() - wb, 2);
        chk("corr_w0", {wr_addr[wb], wr_req[wb], wr_data[wb]}, {8'd1, 8'h04, wd(1, 2)});
        chk("corr_w1", {wr_addr[wb+1], wr_req[wb+1], wr_data[wb+1]}, {8'd1, 8'h20, wd(1, 5)});
        chk("corr_cnts", {corr_cnt_o, uncorr_cnt_o}, {16'd2, 16'd0});

        // uncorrectable way 3 (10) and way 6 (11) at set 2
        do_reset();
        em[2] = (16'h2 << 6) | (16'h3 << 12);
        wb = wr_addr.size(); bi = irq_n;
        gnt_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 200 && irq_n < bi + 1; i++) @(negedge clk_i);
        en_i = 1'b0;
        chk("unc_irq_pulse_end", uncorr_irq_o, 0);
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
        chk("unc_irq_count", irq_n - bi, 1);
        chk("unc_no_write", wr_addr.size() - wb, 0);
        chk("unc_cnts", {corr_cnt_o, uncorr_cnt_o}, {16'd0, 16'd2});
        chk("unc_loc", {uncorr_idx_o, uncorr_way_o}, {2'd2, 3'd3});

        // grant stalls, en_i dropped during WRITE
        do_reset();
        em[0] = (16'h1 << 2) | (16'h1 << 8);
        wb = wr_addr.size(); rb = rd_addr.size();
        en_i = 1'b1;
        for (int i = 0; i < 20 && req_o != '1; i++) @(negedge clk_i);
        hold_ok = 1;
        for (int i = 0; i < 5; i++) begin
            if (!(req_o == '1 && addr_o == 0 && !we_o)) hold_ok = 0;
            @(negedge clk_i);
        end
        chk("stall_read_hold", hold_ok, 1);
        gnt_i = 1'b1;
        @(negedge clk_i);
        gnt_i = 1'b0;
        for (int i = 0; i < 10 && !we_o; i++) @(negedge clk_i);
        en_i = 1'b0;
        hold_ok = 1;
        for (int i = 0; i < 3; i++) begin
            if (!(req_o == 8'h02 && we_o && addr_o == 0 && wdata_o == wd(0, 1))) hold_ok = 0;
            @(negedge clk_i);
        end
        chk("stall_write_hold", hold_ok, 1);
        gnt_i = 1'b1;
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        chk("stall_write_count", wr_addr.size() - wb, 2);
        chk("stall_w0", {wr_req[wb], wr_data[wb]}, {8'h02, wd(0, 1)});
        chk("stall_w1", {wr_req[wb+1], wr_data[wb+1]}, {8'h10, wd(0, 4)});
        chk("endrop_reads", rd_addr.size() - rb, 1);
        chk("endrop_idle", busy_o, 0);

        // external write to the same set aborts the pending write-backs
        do_reset();
        em[0] = (16'h1 << 2) | (16'h1 << 8);
        wb = wr_addr.size();
        en_i = 1'b1;
        for (int i = 0; i < 20 && req_o != '1; i++) @(negedge clk_i);
        gnt_i = 1'b1;
        @(negedge clk_i);
        gnt_i = 1'b0;
        for (int i = 0; i < 10 && !we_o; i++) @(negedge clk_i);
        chk("abort_write_req", {we_o, req_o}, {1'b1, 8'h02});
        ext_wr_i = 1'b1; ext_idx_i = 2'd0;
        @(negedge clk_i);
        ext_wr_i = 1'b0; en_i = 1'b0;
        chk("abort_req_drop", {we_o, req_o}, 0);
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
        chk("abort_no_write", wr_addr.size() - wb, 0);
        chk("abort_cnts", {corr_cnt_o, uncorr_cnt_o}, {16'd2, 16'd0});

        // saturation of the uncorrectable counter, then clear in an increment cycle
        do_reset();
        for (int s = 0; s < NS; s++) em[s] = 16'hAAAA;
        gnt_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 40000 && uncorr_cnt_o != 16'hFFFF; i++) @(negedge clk_i);
        chk("sat_reach", uncorr_cnt_o, 16'hFFFF);
        bi = irq_n;
        for (int i = 0; i < 50 && irq_n < bi + 2; i++) @(negedge clk_i);
        chk("sat_hold", {uncorr_cnt_o, 16'(irq_n - bi)}, {16'hFFFF, 16'd2});
        chk("sat_corr_zero", corr_cnt_o, 0);
        for (int i = 0; i < 20 && !(req_o == '1 && !we_o); i++) @(negedge clk_i);
        @(negedge clk_i);
        clr_cnt_i = 1'b1;
        @(negedge clk_i);
        clr_cnt_i = 1'b0;
        chk("clr_wins", uncorr_cnt_o, 0);
        repeat (4) @(negedge clk_i);
        chk("clr_then_count", uncorr_cnt_o, 16'd8);
        en_i = 1'b0;
        for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
